// File: rtl/fecha_pkg.sv
// rtl/fecha_pkg.sv - shared types and constants for the date/time register sequencer
package fecha_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_LOAD = 3'd2,
    WR_REQ  = 3'd3,
    WR_LOAD = 3'd4
  } state_t;

  localparam int NUM_REGS = 6;

  localparam logic [2:0] IDX_SEG  = 3'd0;
  localparam logic [2:0] IDX_MIN  = 3'd1;
  localparam logic [2:0] IDX_HORA = 3'd2;
  localparam logic [2:0] IDX_DIA  = 3'd3;
  localparam logic [2:0] IDX_MES  = 3'd4;
  localparam logic [2:0] IDX_ANIO = 3'd5;

  localparam logic [7:0] DEF_BASE_ADDR = 8'h21;

  function automatic logic bcd_ok(input logic [7:0] d);
    return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/fecha_hora_ctrl_ack_timer.sv
// rtl/fecha_hora_ctrl_ack_timer.sv - bus acknowledge watchdog counter
// expired is high once the count reaches TIMEOUT-1; the count holds there until cleared.
module ack_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/fecha_hora_ctrl.sv
// rtl/fecha_hora_ctrl.sv - RTC sweep / user edit arbiter for the six date/time holding registers
// Optional BCD_CHECK_EN: reads with a nibble above 9 are dropped and flag err.
module fecha_hora_ctrl
  import fecha_pkg::*;
#(
  parameter int         TIMEOUT   = 64,
  parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_tick,
  input  logic       edit_req,
  input  logic [2:0] edit_sel,
  input  logic [7:0] edit_dato,
  output logic       edit_done,
  output logic       rtc_req,
  output logic       rtc_we,
  output logic [7:0] rtc_addr,
  output logic [7:0] rtc_wdata,
  input  logic [7:0] rtc_rdata,
  input  logic       rtc_ack,
  output logic [5:0] reg_en,
  output logic [7:0] reg_dato,
  output logic       busy,
  output logic       err
);

  state_t     state, state_nx;
  logic [2:0] idx;
  logic       rd_pend;
  logic [7:0] rdata_q;
  logic       bad_q;
  logic       done_q;
  logic       err_q;
  logic       sweep_fault;
  logic       expired;
  logic       sel_ok;
  logic       bcd_bad;

  assign sel_ok = (edit_sel <= IDX_ANIO);

`ifdef BCD_CHECK_EN
  assign bcd_bad = !bcd_ok(rtc_rdata);
`else
  assign bcd_bad = 1'b0;
`endif

  // Timer is held clear outside REQ states so every transfer starts from zero.
  ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!rtc_req),
    .en      (rtc_req),
    .expired (expired)
  );

  always_comb begin
    state_nx  = state;
    rtc_req   = 1'b0;
    rtc_we    = 1'b0;
    rtc_addr  = 8'h00;
    rtc_wdata = 8'h00;
    reg_en    = 6'b000000;
    reg_dato  = 8'h00;
    edit_done = done_q;
    case (state)
      IDLE: begin
        // done_q masks the still-held edit_req in the cycle its done pulse is seen.
        if (edit_req && !done_q) begin
          if (sel_ok) state_nx = WR_REQ;
        end else if (rd_pend) begin
          state_nx = RD_REQ;
        end
      end
      RD_REQ: begin
        rtc_req  = 1'b1;
        rtc_addr = BASE_ADDR + {5'd0, idx};
        if (rtc_ack)      state_nx = RD_LOAD;
        else if (expired) state_nx = IDLE;
      end
      RD_LOAD: begin
        if (!bad_q) begin
          reg_en   = 6'(1) << idx;
          reg_dato = rdata_q;
        end
        state_nx = (idx == IDX_ANIO) ? IDLE : RD_REQ;
      end
      WR_REQ: begin
        rtc_req   = 1'b1;
        rtc_we    = 1'b1;
        rtc_addr  = BASE_ADDR + {5'd0, edit_sel};
        rtc_wdata = edit_dato;
        if (rtc_ack)      state_nx = WR_LOAD;
        else if (expired) state_nx = IDLE;
      end
      WR_LOAD: begin
        reg_en    = 6'(1) << edit_sel;
        reg_dato  = edit_dato;
        edit_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      rd_pend     <= 1'b0;
      rdata_q     <= 8'h00;
      bad_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sweep_fault <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      if (rd_tick) rd_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (edit_req && !done_q) begin
            if (!sel_ok) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end else if (rd_pend) begin
            rd_pend     <= 1'b0;
            idx         <= IDX_SEG;
            sweep_fault <= 1'b0;
          end
        end
        RD_REQ: begin
          if (rtc_ack) begin
            rdata_q <= rtc_rdata;
            bad_q   <= bcd_bad;
            if (bcd_bad) begin
              err_q       <= 1'b1;
              sweep_fault <= 1'b1;
            end
          end else if (expired) begin
            err_q <= 1'b1;
          end
        end
        RD_LOAD: begin
          if (idx == IDX_ANIO) begin
            if (!sweep_fault) err_q <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        WR_REQ: begin
          if (!rtc_ack && expired) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_fecha_hora_ctrl.sv
// tb/tb_fecha_hora_ctrl.sv - randomized self-checking bench for fecha_hora_ctrl
module tb_fecha_hora_ctrl;

  localparam int         TIMEOUT = 64;
  localparam logic [7:0] BASE    = 8'h21;
`ifdef BCD_CHECK_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  typedef struct packed { logic we; logic [7:0] addr; logic [7:0] wdata; } req_t;
  typedef struct packed { logic [5:0] en; logic [7:0] dato; } load_t;

  logic clk = 1'b0;
  logic reset, rd_tick, edit_req, rtc_ack;
  logic [2:0] edit_sel;
  logic [7:0] edit_dato, rtc_rdata;
  logic edit_done, rtc_req, rtc_we, busy, err;
  logic [7:0] rtc_addr, rtc_wdata, reg_dato;
  logic [5:0] reg_en;

  always #5 clk = ~clk;

  fecha_hora_ctrl dut (
    .clk(clk), .reset(reset), .rd_tick(rd_tick), .edit_req(edit_req),
    .edit_sel(edit_sel), .edit_dato(edit_dato), .edit_done(edit_done),
    .rtc_req(rtc_req), .rtc_we(rtc_we), .rtc_addr(rtc_addr), .rtc_wdata(rtc_wdata),
    .rtc_rdata(rtc_rdata), .rtc_ack(rtc_ack), .reg_en(reg_en), .reg_dato(reg_dato),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;

  req_t  exp_req[$];
  load_t exp_load[$];
  req_t  obs_req[$];
  load_t obs_load[$];
  logic  exp_err = 1'b0;
  logic  sweep_fault_m = 1'b0;

  int   stall_idx = -1;
  bit   stall_wr = 1'b0;
  int   ack_delay_max = 3;
  bit   fixed_data = 1'b0;
  int   force_idx = -1;
  logic [7:0] force_val = 8'h00;

  int   busy_cycles = 0, done_count = 0, rd_ack_count = 0;
  logic prev_req = 1'b0;
  bit   cur_valid = 1'b0;
  req_t cur;
  int   req_len = 0, wait_cnt = 0, delay = 0, rd_i = 0;
  logic [7:0] rd_d;
  load_t lp;

  logic [5:0] lit_en [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
  logic [7:0] lit_dat[6] = '{8'h30, 8'h45, 8'h12, 8'h07, 8'h04, 8'h16};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic we, input logic [7:0] a, input logic [7:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic load_t mk_load(input logic [5:0] en, input logic [7:0] d);
    load_t l;
    l.en = en; l.dato = d;
    return l;
  endfunction

  function automatic logic [7:0] rand_bcd();
    return {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
  endfunction

  function automatic bit bcd_valid(input logic [7:0] d);
    return (d / 16 < 10) && (d % 16 < 10);
  endfunction

  function automatic bit is_stalled(input req_t r);
    if (r.we) return stall_wr;
    return (stall_idx >= 0) && (r.addr == BASE + 8'(stall_idx));
  endfunction

  // Monitor and RTC bus responder: checks every cycle, then answers the open request.
  initial begin
    rtc_ack = 1'b0; rtc_rdata = 8'h00;
    forever begin
      @(negedge clk);
      rtc_ack = 1'b0;
      if (reset) begin
        prev_req = 1'b0; cur_valid = 1'b0;
      end else begin
        if (!rtc_req && prev_req && cur_valid) begin
          if (is_stalled(cur)) check("timeout_len", 32'(req_len), 32'(TIMEOUT));
          cur_valid = 1'b0;
        end
        if (rtc_req && !prev_req) begin
          check("req_expected", 32'(exp_req.size() != 0), 1);
          cur_valid = (exp_req.size() != 0);
          if (cur_valid) begin
            cur = exp_req.pop_front();
            check("req_we", 32'(rtc_we), 32'(cur.we));
            check("req_addr", 32'(rtc_addr), 32'(cur.addr));
            if (cur.we) check("req_wdata", 32'(rtc_wdata), 32'(cur.wdata));
          end
          obs_req.push_back(mk_req(rtc_we, rtc_addr, rtc_wdata));
          req_len = 0; wait_cnt = 0;
          delay = $urandom_range(ack_delay_max, 0);
        end
        if (rtc_req) req_len++;
        if (reg_en != 6'b0) begin
          check("en_onehot", 32'($onehot(reg_en)), 1);
          check("en_without_req", 32'(rtc_req), 0);
          check("load_expected", 32'(exp_load.size() != 0), 1);
          if (exp_load.size() != 0) begin
            lp = exp_load.pop_front();
            check("load_en", 32'(reg_en), 32'(lp.en));
            check("load_dato", 32'(reg_dato), 32'(lp.dato));
          end
          obs_load.push_back(mk_load(reg_en, reg_dato));
        end
        if (rtc_req || reg_en != 6'b0) check("busy_active", 32'(busy), 1);
        if (busy) busy_cycles++;
        if (edit_done) done_count++;
        if (rtc_req && cur_valid && !is_stalled(cur)) begin
          if (wait_cnt >= delay) begin
            rtc_ack = 1'b1;
            if (cur.we) begin
              exp_load.push_back(mk_load(6'(1) << edit_sel, edit_dato));
            end else begin
              rd_i = int'(cur.addr - BASE);
              if (rd_i == force_idx) rd_d = force_val;
              else if (fixed_data)   rd_d = lit_dat[rd_i];
              else                   rd_d = rand_bcd();
              rtc_rdata = rd_d;
              rd_ack_count++;
              if (BCD_ON && !bcd_valid(rd_d)) begin
                exp_err = 1'b1; sweep_fault_m = 1'b1;
              end else begin
                exp_load.push_back(mk_load(6'(1) << rd_i, rd_d));
              end
            end
            cur_valid = 1'b0;
          end else begin
            wait_cnt++;
          end
        end
        prev_req = rtc_req;
      end
    end
  end

  task automatic clear_obs();
    obs_req.delete(); obs_load.delete(); busy_cycles = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_req.size() != 0) && n < 4000);
    check("idle_reached", 32'(busy || exp_req.size() != 0), 0);
    check("loads_drained", 32'(exp_load.size()), 0);
  endtask

  task automatic push_reads(input int n);
    for (int k = 0; k < n; k++) exp_req.push_back(mk_req(1'b0, BASE + 8'(k), 8'h00));
  endtask

  task automatic do_sweep();
    push_reads((stall_idx >= 0) ? stall_idx + 1 : 6);
    sweep_fault_m = 1'b0;
    @(posedge clk); #1 rd_tick = 1'b1;
    @(posedge clk); #1 rd_tick = 1'b0;
    wait_idle();
    if (stall_idx >= 0) exp_err = 1'b1;
    else if (!sweep_fault_m) exp_err = 1'b0;
    check("err_after_sweep", 32'(err), 32'(exp_err));
  endtask

  task automatic do_edit(input logic [2:0] sel, input logic [7:0] dato, input bit with_tick,
                         output int lat);
    int d0;
    d0 = done_count;
    if (sel <= 3'd5) exp_req.push_back(mk_req(1'b1, BASE + {5'd0, sel}, dato));
    if (with_tick) begin push_reads(6); sweep_fault_m = 1'b0; end
    @(posedge clk); #1;
    edit_sel = sel; edit_dato = dato; edit_req = 1'b1; rd_tick = with_tick;
    @(posedge clk); #1 rd_tick = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!edit_done && lat < 3000);
    check("edit_done_seen", 32'(edit_done), 1);
    @(posedge clk); #1 edit_req = 1'b0;
    wait_idle();
    if (sel > 3'd5 || stall_wr) exp_err = 1'b1;
    if (with_tick && !sweep_fault_m) exp_err = 1'b0;
    check("edit_done_count", 32'(done_count - d0), 1);
    check("err_after_edit", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, n, r;
    reset = 1'b1; rd_tick = 1'b0; edit_req = 1'b0; edit_sel = 3'd0; edit_dato = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rtc_req", 32'(rtc_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_reg_en", 32'(reg_en), 0);
    check("rst_edit_done", 32'(edit_done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_addr_we", 32'({rtc_we, rtc_addr}), 0);
    @(posedge clk); #2 reset = 1'b0;

    // Fixed-data sweep at minimum latency
    clear_obs(); ack_delay_max = 0; fixed_data = 1'b1;
    do_sweep();
    fixed_data = 1'b0;
    check("sweep_busy_cycles", 32'(busy_cycles), 12);
    check("sweep_load_count", 32'(obs_load.size()), 6);
    for (int k = 0; k < 6 && k < obs_load.size(); k++) begin
      check("sweep_lit_en", 32'(obs_load[k].en), 32'(lit_en[k]));
      check("sweep_lit_dato", 32'(obs_load[k].dato), 32'(lit_dat[k]));
    end
    check("sweep_err_lit", 32'(err), 0);

    // Single edit at minimum latency
    clear_obs();
    do_edit(3'd1, 8'h59, 1'b0, lat);
    check("edit_busy_cycles", 32'(busy_cycles), 2);
    check("edit_lit_req", 32'(obs_req.size() > 0 ? obs_req[0] : 17'h0), 32'({1'b1, 8'h22, 8'h59}));
    check("edit_lit_load", 32'(obs_load.size() > 0 ? obs_load[0] : 14'h0), 32'({6'b000010, 8'h59}));
    ack_delay_max = 3;

    // Tick and edit in the same cycle: edit goes first
    clear_obs();
    do_edit(3'd4, 8'h11, 1'b1, lat);
    check("prio_req_count", 32'(obs_req.size()), 7);
    check("prio_first_req", 32'(obs_req.size() > 0 ? obs_req[0] : 17'h0), 32'({1'b1, 8'h25, 8'h11}));
    check("prio_first_load", 32'(obs_load.size() > 0 ? obs_load[0] : 14'h0), 32'({6'b010000, 8'h11}));

    // Edit raised at the third read ack waits for the whole sweep
    clear_obs();
    push_reads(6);
    exp_req.push_back(mk_req(1'b1, 8'h23, 8'h42));
    sweep_fault_m = 1'b0; a0 = rd_ack_count;
    @(posedge clk); #1 rd_tick = 1'b1;
    @(posedge clk); #1 rd_tick = 1'b0;
    n = 0;
    while (rd_ack_count < a0 + 3 && n < 500) begin @(posedge clk); n++; end
    #1 edit_sel = 3'd2; edit_dato = 8'h42; edit_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!edit_done && n < 3000);
    check("mid_edit_done", 32'(edit_done), 1);
    @(posedge clk); #1 edit_req = 1'b0;
    wait_idle();
    exp_err = 1'b0;
    check("mid_load_count", 32'(obs_load.size()), 7);
    check("mid_last_read", 32'(obs_load.size() > 5 ? obs_load[5].en : 6'h0), 32'(6'b100000));
    check("mid_write_load", 32'(obs_load.size() > 6 ? obs_load[6] : 14'h0), 32'({6'b000100, 8'h42}));

    // Read timeout on idx 2, then a clean sweep clears err
    clear_obs(); stall_idx = 2;
    do_sweep();
    stall_idx = -1;
    check("to_err_lit", 32'(err), 1);
    check("to_load_count", 32'(obs_load.size()), 2);
    check("to_loads_bits", 32'(obs_load.size() > 1 ? obs_load[0].en | obs_load[1].en : 6'h0), 32'(6'b000011));
    do_sweep();
    check("to_cleared_lit", 32'(err), 0);

    // Write timeout
    clear_obs(); stall_wr = 1'b1;
    do_edit(3'd3, 8'h27, 1'b0, lat);
    stall_wr = 1'b0;
    check("wto_no_load", 32'(obs_load.size()), 0);
    check("wto_err_lit", 32'(err), 1);
    do_sweep();

    // Out-of-range edit select: no bus cycle
    clear_obs();
    do_edit(3'd7, 8'h33, 1'b0, lat);
    check("badsel_latency", 32'(lat), 1);
    check("badsel_no_req", 32'(obs_req.size()), 0);
    check("badsel_err_lit", 32'(err), 1);
    do_sweep();

    // Non-BCD read data at idx 0
    clear_obs(); force_idx = 0; force_val = 8'h3A;
    do_sweep();
    force_idx = -1;
`ifdef BCD_CHECK_EN
    check("bcd_load_count", 32'(obs_load.size()), 5);
    check("bcd_err_lit", 32'(err), 1);
`else
    check("bcd_load_count", 32'(obs_load.size()), 6);
    check("bcd_pass_dato", 32'(obs_load.size() > 0 ? obs_load[0].dato : 8'h0), 32'(8'h3A));
`endif
    do_sweep();

    // Randomized mix
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(9, 0);
      if (r < 4)       do_sweep();
      else if (r < 8)  do_edit(3'($urandom_range(5, 0)), rand_bcd(), 1'b0, lat);
      else if (r == 8) do_edit(3'($urandom_range(5, 0)), rand_bcd(), 1'b1, lat);
      else             do_edit(3'($urandom_range(7, 6)), rand_bcd(), 1'b0, lat);
    end

    // Asynchronous reset in the middle of a stalled read
    clear_obs(); stall_idx = 0;
    push_reads(1);
    @(posedge clk); #1 rd_tick = 1'b1;
    @(posedge clk); #1 rd_tick = 1'b0;
    repeat (5) @(posedge clk);
    #1 rd_tick = 1'b1;
    @(posedge clk); #1 rd_tick = 1'b0;
    check("rstmid_req_up", 32'(rtc_req), 1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("rstmid_req", 32'(rtc_req), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_reg_en", 32'(reg_en), 0);
    exp_req.delete(); exp_load.delete(); exp_err = 1'b0; stall_idx = -1;
    @(posedge clk); #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_idle", 32'(busy), 0);
    check("rstmid_no_new_req", 32'(obs_req.size()), 1);
    check("rstmid_err", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
